kernel_sequencer: RTL and testbench

Sequences one `kernel` MAC/compare datapath for the MNIST accelerator.
- Accepts a job descriptor: mode, tap count and bias.
- Streams data/weight taps into the kernel under valid/ready flow control.
- In conv mode, issues the bias/requantise step.
- Captures the 8-bit result and presents it on a valid/ready output.
- Sits between the layer scheduler / line buffers and a single `kernel` instance, which is instantiated alongside it, not inside it.

---
 rtl/kernel_pkg.sv | 20 ++
 rtl/kernel_sequencer.sv | 111 +++++++++++
 tb/tb_kernel_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kernel_pkg.sv
// Shared constants and FSM encoding for the kernel sequencer.
package kernel_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int WEIGHT_WIDTH_DEF = 8;
  localparam int TAP_W_DEF        = 6;

  localparam logic MODE_CONV = 1'b0;
  localparam logic MODE_POOL = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    ACCUM   = 3'd2,
    BIAS    = 3'd3,
    CAPTURE = 3'd4,
    OUTPUT  = 3'd5
  } state_e;

endpackage

// File: rtl/kernel_sequencer.sv
// Drives one external kernel datapath through a job: clear, stream taps,
// optional bias/requantise step, then capture and present the 8-bit result.
module kernel_sequencer
  import kernel_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int TAP_W        = TAP_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic [TAP_W-1:0]        num_taps,
  input  logic [WEIGHT_WIDTH-1:0] bias,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [WEIGHT_WIDTH-1:0] in_weight,
  output logic                    k_init,
  output logic                    k_en,
  output logic                    k_mode,
  output logic                    k_bias_en,
  output logic [DATA_WIDTH-1:0]   k_data,
  output logic [WEIGHT_WIDTH-1:0] k_weight,
  input  logic [DATA_WIDTH-1:0]   k_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data
);

  state_e                  state_q, state_d;
  logic [TAP_W-1:0]        tapCnt_q, tapCnt_d;
  logic [TAP_W-1:0]        numTaps_q;
  logic                    mode_q;
  logic [WEIGHT_WIDTH-1:0] bias_q;
  logic [DATA_WIDTH-1:0]   outData_q;
  logic                    fire;
  logic                    lastTap;

  assign fire    = in_valid & in_ready;
  assign lastTap = (tapCnt_q == (numTaps_q - TAP_W'(1)));

  always_comb begin
    state_d  = state_q;
    tapCnt_d = tapCnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        tapCnt_d = '0;
        if (numTaps_q != '0)          state_d = ACCUM;
        else if (mode_q == MODE_CONV) state_d = BIAS;
        else                          state_d = CAPTURE;
      end
      ACCUM: begin
        if (fire) begin
          tapCnt_d = tapCnt_q + TAP_W'(1);
          if (lastTap) state_d = (mode_q == MODE_CONV) ? BIAS : CAPTURE;
        end
      end
      BIAS:    state_d = CAPTURE;
      CAPTURE: state_d = OUTPUT;
      OUTPUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job fields are only captured in IDLE so a start during a job cannot corrupt it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tapCnt_q  <= '0;
      numTaps_q <= '0;
      mode_q    <= MODE_CONV;
      bias_q    <= '0;
      outData_q <= '0;
    end else begin
      state_q  <= state_d;
      tapCnt_q <= tapCnt_d;
      if (state_q == IDLE && start) begin
        numTaps_q <= num_taps;
        mode_q    <= mode;
        bias_q    <= bias;
      end
      if (state_q == CAPTURE) outData_q <= k_result;
    end
  end

  // Outputs are gated by rst so the reset cycle itself is already quiet.
  assign busy      = !rst && (state_q != IDLE);
  assign in_ready  = !rst && (state_q == ACCUM);
  assign out_valid = !rst && (state_q == OUTPUT);
  assign k_init    = rst || (state_q == CLEAR);
  assign k_bias_en = !rst && (state_q == BIAS);
  assign k_en      = fire || k_bias_en;
  assign k_mode    = mode_q;
  assign k_data    = (state_q == ACCUM) ? in_data : '0;
  assign out_data  = outData_q;

  always_comb begin
    k_weight = '0;
    if (state_q == ACCUM)     k_weight = in_weight;
    else if (state_q == BIAS) k_weight = bias_q;
  end

endmodule

// File: tb/tb_kernel_sequencer.sv
// Directed bench for kernel_sequencer with a behavioural kernel datapath
// (signed MAC, >>4 + bias, ReLU then >>3; pool keeps unsigned max from 0).
module tb_kernel_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic [5:0] num_taps;
  logic [7:0] bias;
  logic       busy;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] in_weight;
  logic       k_init;
  logic       k_en;
  logic       k_mode;
  logic       k_bias_en;
  logic [7:0] k_data;
  logic [7:0] k_weight;
  logic [7:0] k_result;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  int checks   = 0;
  int failures = 0;

  int biasPulses = 0;
  int fires      = 0;
  int readyHigh  = 0;
  int validHigh  = 0;
  int exclViol   = 0;

  always #5 clk = ~clk;

  kernel_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .num_taps  (num_taps),
    .bias      (bias),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_weight (in_weight),
    .k_init    (k_init),
    .k_en      (k_en),
    .k_mode    (k_mode),
    .k_bias_en (k_bias_en),
    .k_data    (k_data),
    .k_weight  (k_weight),
    .k_result  (k_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Behavioural stand-in for the kernel instance that sits beside the sequencer.
  logic signed [31:0] acc = 32'sd0;
  logic signed [31:0] prod;
  logic signed [31:0] biased;
  logic signed [31:0] shifted;
  logic signed [31:0] dataExt;

  always_comb begin
    prod    = $signed(k_data) * $signed(k_weight);
    biased  = (acc >>> 4) + $signed(k_weight);
    shifted = acc >>> 3;
    dataExt = $signed({24'd0, k_data});
    if (k_mode) k_result = acc[7:0];
    else if (acc < 0) k_result = 8'd0;
    else if (shifted > 32'sd255) k_result = 8'd255;
    else k_result = shifted[7:0];
  end

  always @(posedge clk) begin
    if (k_init) acc <= 32'sd0;
    else if (k_en) begin
      if (k_bias_en) acc <= biased;
      else if (!k_mode) acc <= acc + prod;
      else if (dataExt > acc) acc <= dataExt;
    end
  end

  // Event counters sampled at the clock edge for cross-cycle checks.
  always @(posedge clk) begin
    if (k_bias_en) biasPulses <= biasPulses + 1;
    if (in_valid && in_ready) fires <= fires + 1;
    if (in_ready) readyHigh <= readyHigh + 1;
    if (out_valid) validHigh <= validHigh + 1;
    if (k_init && (k_en || k_bias_en)) exclViol <= exclViol + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [5:0] taps, input logic [7:0] b);
    start    = 1'b1;
    mode     = m;
    num_taps = taps;
    bias     = b;
    tick();
    start = 1'b0;
  endtask

  task automatic sendTap(input logic [7:0] d, input logic [7:0] w, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid  = 1'b1;
    in_data   = d;
    in_weight = w;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checkOutput("tap_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("tap_kdata", {24'd0, k_data}, {24'd0, d});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    checkOutput("hs_busy", {31'd0, busy}, 32'd0);
    checkOutput("hs_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int n;
    int b0;
    int f0;
    int r0;
    int v0;

    rst = 1'b1; start = 1'b0; mode = 1'b0; num_taps = '0; bias = '0;
    in_valid = 1'b0; in_data = '0; in_weight = '0; out_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_kinit", {31'd0, k_init}, 32'd1);
    checkOutput("rst_ken", {31'd0, k_en}, 32'd0);
    checkOutput("rst_kbias", {31'd0, k_bias_en}, 32'd0);
    checkOutput("rst_outdata", {24'd0, out_data}, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("idle_kinit", {31'd0, k_init}, 32'd0);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);

    // Conv: 96 >> 4 = 6, + 10 = 16, ReLU/requant -> 2
    applyStimulus(1'b0, 6'd3, 8'd10);
    checkOutput("clear_kinit", {31'd0, k_init}, 32'd1);
    checkOutput("clear_busy", {31'd0, busy}, 32'd1);
    checkOutput("clear_ready", {31'd0, in_ready}, 32'd0);
    b0 = biasPulses;
    f0 = fires;
    sendTap(8'd16, 8'd2, 0);
    sendTap(8'd32, 8'd4, 0);
    sendTap(8'hF8, 8'd8, 0);
    checkOutput("bias_en", {31'd0, k_bias_en}, 32'd1);
    checkOutput("bias_ken", {31'd0, k_en}, 32'd1);
    checkOutput("bias_weight", {24'd0, k_weight}, 32'd10);
    checkOutput("bias_data", {24'd0, k_data}, 32'd0);
    waitValid(n);
    checkOutput("conv_latency", n, 32'd2);
    checkOutput("conv_out", {24'd0, out_data}, 32'd2);
    checkOutput("conv_biaspulses", biasPulses - b0, 32'd1);
    checkOutput("conv_fires", fires - f0, 32'd3);
    handshake();

    // Conv negative: -256 -> ReLU clamp
    applyStimulus(1'b0, 6'd1, 8'd0);
    sendTap(8'hF0, 8'd16, 0);
    waitValid(n);
    checkOutput("neg_out", {24'd0, out_data}, 32'd0);
    handshake();

    // Pool with bubbles between taps
    b0 = biasPulses;
    f0 = fires;
    applyStimulus(1'b1, 6'd4, 8'h55);
    checkOutput("pool_kmode", {31'd0, k_mode}, 32'd1);
    sendTap(8'd5, 8'h11, 2);
    sendTap(8'd200, 8'h22, 2);
    sendTap(8'd17, 8'h33, 2);
    sendTap(8'd9, 8'h44, 2);
    waitValid(n);
    checkOutput("pool_latency", n, 32'd1);
    checkOutput("pool_out", {24'd0, out_data}, 32'd200);
    checkOutput("pool_biaspulses", biasPulses - b0, 32'd0);
    checkOutput("pool_fires", fires - f0, 32'd4);
    handshake();

    // Backpressure with a stray start while holding the result
    applyStimulus(1'b1, 6'd1, 8'd0);
    sendTap(8'd42, 8'd0, 0);
    waitValid(n);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_data", {24'd0, out_data}, 32'd42);
      start = (i == 2);
      tick();
    end
    start = 1'b0;
    handshake();
    tick();
    checkOutput("bp_noqueue", {31'd0, busy}, 32'd0);

    // Zero-tap jobs never open the tap port
    r0 = readyHigh;
    applyStimulus(1'b0, 6'd0, 8'd16);
    waitValid(n);
    checkOutput("zconv_latency", n, 32'd3);
    checkOutput("zconv_out", {24'd0, out_data}, 32'd2);
    handshake();
    applyStimulus(1'b1, 6'd0, 8'd0);
    waitValid(n);
    checkOutput("zpool_latency", n, 32'd2);
    checkOutput("zpool_out", {24'd0, out_data}, 32'd0);
    handshake();
    checkOutput("zero_ready", readyHigh - r0, 32'd0);

    // Abort mid-accumulation, then recover
    v0 = validHigh;
    applyStimulus(1'b0, 6'd5, 8'd3);
    sendTap(8'd1, 8'd1, 0);
    sendTap(8'd2, 8'd2, 0);
    rst = 1'b1;
    #1;
    checkOutput("abort_kinit", {31'd0, k_init}, 32'd1);
    checkOutput("abort_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_idle_ready", {31'd0, in_ready}, 32'd0);
    repeat (10) tick();
    checkOutput("abort_novalid", validHigh - v0, 32'd0);
    applyStimulus(1'b1, 6'd1, 8'd0);
    sendTap(8'd7, 8'd0, 0);
    waitValid(n);
    checkOutput("recover_out", {24'd0, out_data}, 32'd7);
    handshake();

    checkOutput("ctrl_exclusive", exclViol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
